arbitro_round_robin: RTL and testbench
======================================

Name: arbitro_round_robin

Overview:
- Moves words from the 4 input FIFOs (0-3) to the 4 output FIFOs (4-7) of the switch.
- Each word carries its own destination in bits [DEST_MSB:DEST_LSB].
- One word is transferred per cycle. A fair round-robin grant replaces fixed priority.
- Back-pressure from the output FIFOs' almost-full flags is honoured.
- Sits between the input FIFO bank and the output FIFO bank; enabled by the main state machine when it is in its active state.

Parameters:
- DATA_WIDTH, 10, word width.
- DEST_MSB, 9, MSB of the destination field.
- DEST_LSB, 8, LSB of the destination field (field is 2 bits: 0->FIFO4 ... 3->FIFO7).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  arbitration allowed (from main FSM active state).
- empty0..empty3  in  1 each  input FIFO empty flags.
- data_in0..data_in3  in  DATA_WIDTH each  show-ahead head word of each input FIFO; valid whenever emptyN=0.
- almost_full4..almost_full7  in  1 each  output FIFO almost-full flags.
- pop0..pop3  out  1 each  combinational pop to input FIFOs.
- push4..push7  out  1 each  registered push to output FIFOs.
- data_out  out  DATA_WIDTH  registered word shared by all output FIFOs.
- grant  out  2  registered index of the last granted input.
- idle  out  1  FSM in IDLE.
- stall  out  1  FSM in STALL.

Behaviour:
- Eligibility: input i is eligible when emptyi=0, enable=1, and almost_full of destination data_ini[9:8] is 0.
  - Blocking is per destination: a full FIFO5 does not block words headed to FIFO4/6/7.
- Round-robin selection:
  - Search order starts at (grant+1) mod 4 and takes the first eligible input.
  - The winner's popi is asserted combinationally in the same cycle; at most one pop per cycle.
- Registered stage:
  - On the edge where popi=1: data_out <= data_ini; push(4+dest) <= 1; grant <= i.
  - Otherwise all push <= 0; data_out and grant hold.
  - Latency: pop at cycle N -> push/data_out visible in N+1 -> output FIFO captures at edge N+1.
- Back-pressure slack: almost_full is sampled one cycle before the push lands. The threshold programmed in alto must leave at least 1 free slot; the arbiter does not track occupancy.
- FSM (2-bit):
  - IDLE: enable=0 or all inputs empty.
  - ACTIVE: a grant was issued this cycle.
  - STALL: at least one input non-empty, enable=1, and none eligible.
  - Next state is evaluated every cycle from the same conditions. idle=(state==IDLE), stall=(state==STALL).
- Enable falling mid-transfer: the word popped in the previous cycle still gets its push in the current cycle; no new pops.
- Reset (sync):
  - grant<=3, so the first search starts at input 0.
  - push4..7<=0, data_out<=0, state<=IDLE.
  - A word popped in the cycle reset is asserted is dropped (documented loss).
  - pop0..3 are forced to 0 while reset=1.
- Destination field wrap: the 2-bit field always maps to a valid output; there are no illegal codes.
- Simultaneous pop/almost_full change: the decision uses the values present in the pop cycle only.

Optional Feature:
- STRICT_PRIO_EN defined:
  - Fixed priority, input 0 highest to input 3 lowest; the search always starts at 0.
  - grant is still updated, but only for observation.
- Undefined: round-robin as above (default).

Test Plan:
- Reset 2 cycles, then enable=1 with all empty -> idle=1, all pop/push 0, grant=3, data_out=0.
- Each input holds one word: in0='h0AA (dest0), in1='h1BB, in2='h2CC, in3='h3DD -> pops 0,1,2,3 on consecutive cycles; push4..7 one cycle later each with matching data_out; grant sequence 0,1,2,3.
- Inputs 0 and 1 each hold 3 words to dest 1; the others are empty -> grants alternate 0,1,0,1,0,1; six pushes on push5 in that order.
- almost_full5=1; in0 head 'h1FF, in1 head 'h2F0 -> only in1 pops, push6 with 'h2F0. With no other eligible input -> stall=1 until almost_full5=0, then in0 pops, push5 with 'h1FF.
- Words in flight, reset asserted on the cycle after a pop -> push lines 0 the next cycle, state IDLE, grant=3, no further pops while reset=1.
- STRICT_PRIO_EN, inputs 0 and 2 continuously non-empty to dest 3 -> input 0 always wins; input 2 pops only after input 0 goes empty.

Source files
------------

// File: rtl/arbitro_round_robin_if.sv
// ============================================================================
// arbitro_round_robin_if : FIFO-bank side bundle of the round-robin arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface arbitro_round_robin_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  enable;
  logic                  empty0, empty1, empty2, empty3;
  logic [DATA_WIDTH-1:0] data_in0, data_in1, data_in2, data_in3;
  logic                  almost_full4, almost_full5, almost_full6, almost_full7;
  logic                  pop0, pop1, pop2, pop3;
  logic                  push4, push5, push6, push7;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            grant;
  logic                  idle;
  logic                  stall;

  modport master (
    input  enable,
    input  empty0, empty1, empty2, empty3,
    input  data_in0, data_in1, data_in2, data_in3,
    input  almost_full4, almost_full5, almost_full6, almost_full7,
    output pop0, pop1, pop2, pop3,
    output push4, push5, push6, push7,
    output data_out, grant, idle, stall
  );

  modport slave (
    output enable,
    output empty0, empty1, empty2, empty3,
    output data_in0, data_in1, data_in2, data_in3,
    output almost_full4, almost_full5, almost_full6, almost_full7,
    input  pop0, pop1, pop2, pop3,
    input  push4, push5, push6, push7,
    input  data_out, grant, idle, stall
  );
endinterface

`default_nettype wire

// File: rtl/arbitro_round_robin.sv
// ============================================================================
// arbitro_round_robin : 4-in/4-out word mover with round-robin grant and
// per-destination back-pressure. Define STRICT_PRIO_EN for fixed priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module arbitro_round_robin #(
  parameter int DATA_WIDTH = 10,
  parameter int DEST_MSB   = 9,
  parameter int DEST_LSB   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  arbitro_round_robin_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [1:0]            r_grant;
  logic [3:0]            r_push;

  logic [DATA_WIDTH-1:0] w_data [4];
  logic [1:0]            w_dest [4];
  logic [3:0]            w_empty;
  logic [3:0]            w_af;
  logic [3:0]            w_elig;
  logic [3:0]            w_pop;
  logic [1:0]            w_start;
  logic [1:0]            w_win;
  logic                  w_hit;

  assign w_data[0] = bus.data_in0;
  assign w_data[1] = bus.data_in1;
  assign w_data[2] = bus.data_in2;
  assign w_data[3] = bus.data_in3;
  assign w_empty   = {bus.empty3, bus.empty2, bus.empty1, bus.empty0};
  assign w_af      = {bus.almost_full7, bus.almost_full6, bus.almost_full5, bus.almost_full4};

  // Blocking is per destination: only the head word's own target FIFO matters.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_elig
      assign w_dest[gi] = w_data[gi][DEST_MSB:DEST_LSB];
      assign w_elig[gi] = !w_empty[gi] && bus.enable && !w_af[w_dest[gi]];
    end
  endgenerate

`ifdef STRICT_PRIO_EN
  assign w_start = 2'd0;
`else
  assign w_start = r_grant + 2'd1;
`endif

  // Scan from the farthest offset down so the nearest eligible input wins.
  always_comb begin
    w_hit = 1'b0;
    w_win = w_start;
    for (int k = 3; k >= 0; k--) begin
      if (w_elig[w_start + 2'(k)]) begin
        w_hit = 1'b1;
        w_win = w_start + 2'(k);
      end
    end
  end

  assign w_pop = (w_hit && !reset) ? (4'b0001 << w_win) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= 2'd3;
      r_push     <= 4'b0000;
      r_data_out <= '0;
    end else begin
      r_push <= 4'b0000;
      if (w_hit) begin
        r_data_out           <= w_data[w_win];
        r_push[w_dest[w_win]] <= 1'b1;
        r_grant              <= w_win;
        r_state              <= ST_ACTIVE;
      end else if (bus.enable && !(&w_empty)) begin
        r_state <= ST_STALL;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign bus.pop0     = w_pop[0];
  assign bus.pop1     = w_pop[1];
  assign bus.pop2     = w_pop[2];
  assign bus.pop3     = w_pop[3];
  assign bus.push4    = r_push[0];
  assign bus.push5    = r_push[1];
  assign bus.push6    = r_push[2];
  assign bus.push7    = r_push[3];
  assign bus.data_out = r_data_out;
  assign bus.grant    = r_grant;
  assign bus.idle     = (r_state == ST_IDLE);
  assign bus.stall    = (r_state == ST_STALL);

endmodule

`default_nettype wire

// File: tb/tb_arbitro_round_robin.sv
// Testbench for arbitro_round_robin: input FIFOs modelled as queues, pushes
// checked against a scoreboard of hand-computed expected words.
`default_nettype none

module tb_arbitro_round_robin;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro_round_robin_if #(.DATA_WIDTH(10)) bus ();

  arbitro_round_robin #(
    .DATA_WIDTH(10),
    .DEST_MSB  (9),
    .DEST_LSB  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] port;
    logic [9:0] data;
    logic [1:0] grant;
  } exp_t;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [9:0] q0[$], q1[$], q2[$], q3[$];
  logic [3:0] pops_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_push(input logic [1:0] port, input logic [9:0] data, input logic [1:0] grant);
    sb.push_back('{port: port, data: data, grant: grant});
  endtask

  task automatic refresh();
    bus.empty0   = (q0.size() == 0);
    bus.empty1   = (q1.size() == 0);
    bus.empty2   = (q2.size() == 0);
    bus.empty3   = (q3.size() == 0);
    bus.data_in0 = (q0.size() != 0) ? q0[0] : 10'h000;
    bus.data_in1 = (q1.size() != 0) ? q1[0] : 10'h000;
    bus.data_in2 = (q2.size() != 0) ? q2[0] : 10'h000;
    bus.data_in3 = (q3.size() != 0) ? q3[0] : 10'h000;
  endtask

  // Show-ahead input FIFO model: pops sampled mid-cycle, applied after the edge.
  initial begin
    refresh();
    forever begin
      @(negedge clk);
      pops_s = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
      @(posedge clk);
      #1;
      if (pops_s[0] === 1'b1 && q0.size() != 0) q0.delete(0);
      if (pops_s[1] === 1'b1 && q1.size() != 0) q1.delete(0);
      if (pops_s[2] === 1'b1 && q2.size() != 0) q2.delete(0);
      if (pops_s[3] === 1'b1 && q3.size() != 0) q3.delete(0);
      refresh();
    end
  end

  // Monitor: every push cycle is matched against the scoreboard head.
  initial begin
    logic [3:0] push_v;
    exp_t       e;
    forever begin
      @(negedge clk);
      push_v = {bus.push7, bus.push6, bus.push5, bus.push4};
      if (push_v !== 4'b0000 && !$isunknown(push_v)) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_push: got push=%b data=%0h expected no push", push_v, bus.data_out);
        end else begin
          e = sb.pop_front();
          check("push_port", 32'(push_v), 32'(4'b0001 << e.port));
          check("data_out", 32'(bus.data_out), 32'(e.data));
          check("grant", 32'(bus.grant), 32'(e.grant));
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending pushes expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    reset            = 1'b1;
    bus.enable       = 1'b1;
    bus.almost_full4 = 1'b0;
    bus.almost_full5 = 1'b0;
    bus.almost_full6 = 1'b0;
    bus.almost_full7 = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Reset state, enabled with all inputs empty
    @(negedge clk);
    check("rst_idle", 32'(bus.idle), 32'd1);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_pops", 32'({bus.pop3, bus.pop2, bus.pop1, bus.pop0}), 32'd0);
    check("rst_push", 32'({bus.push7, bus.push6, bus.push5, bus.push4}), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd3);
    check("rst_data", 32'(bus.data_out), 32'd0);

    // One word per input, one per destination
    @(posedge clk); #2;
    q0.push_back(10'h0AA); q1.push_back(10'h1BB); q2.push_back(10'h2CC); q3.push_back(10'h3DD);
    expect_push(2'd0, 10'h0AA, 2'd0);
    expect_push(2'd1, 10'h1BB, 2'd1);
    expect_push(2'd2, 10'h2CC, 2'd2);
    expect_push(2'd3, 10'h3DD, 2'd3);
    drain("four_inputs");

    // Two competing inputs, three words each, all to FIFO5
    @(posedge clk); #2;
    q0.push_back(10'h101); q0.push_back(10'h102); q0.push_back(10'h103);
    q1.push_back(10'h111); q1.push_back(10'h112); q1.push_back(10'h113);
`ifdef STRICT_PRIO_EN
    expect_push(2'd1, 10'h101, 2'd0);
    expect_push(2'd1, 10'h102, 2'd0);
    expect_push(2'd1, 10'h103, 2'd0);
    expect_push(2'd1, 10'h111, 2'd1);
    expect_push(2'd1, 10'h112, 2'd1);
    expect_push(2'd1, 10'h113, 2'd1);
`else
    expect_push(2'd1, 10'h101, 2'd0);
    expect_push(2'd1, 10'h111, 2'd1);
    expect_push(2'd1, 10'h102, 2'd0);
    expect_push(2'd1, 10'h112, 2'd1);
    expect_push(2'd1, 10'h103, 2'd0);
    expect_push(2'd1, 10'h113, 2'd1);
`endif
    drain("alternate");

    // FIFO5 almost full: in0 blocked, in1 (to FIFO6) proceeds, then stall
    @(posedge clk); #2;
    bus.almost_full5 = 1'b1;
    q0.push_back(10'h1FF); q1.push_back(10'h2F0);
    expect_push(2'd2, 10'h2F0, 2'd1);
    drain("backpressure");
    repeat (2) @(negedge clk);
    check("stall_flag", 32'(bus.stall), 32'd1);
    check("stall_idle", 32'(bus.idle), 32'd0);
    @(posedge clk); #2;
    bus.almost_full5 = 1'b0;
    expect_push(2'd1, 10'h1FF, 2'd0);
    drain("unblock");
    @(negedge clk);
    check("post_idle", 32'(bus.idle), 32'd1);

    // Reset on the cycle after a pop: in-flight push lands, queued word stays
    @(posedge clk); #2;
    q2.push_back(10'h0C1); q3.push_back(10'h3E0);
    expect_push(2'd0, 10'h0C1, 2'd2);
    n = 0;
    while (bus.pop2 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pop2_seen", 32'(bus.pop2), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    check("rst_pop_forced", 32'({bus.pop3, bus.pop2, bus.pop1, bus.pop0}), 32'd0);
    @(negedge clk);
    check("rst2_push", 32'({bus.push7, bus.push6, bus.push5, bus.push4}), 32'd0);
    check("rst2_grant", 32'(bus.grant), 32'd3);
    check("rst2_idle", 32'(bus.idle), 32'd1);
    check("rst2_data", 32'(bus.data_out), 32'd0);
    check("rst2_pops", 32'({bus.pop3, bus.pop2, bus.pop1, bus.pop0}), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    expect_push(2'd3, 10'h3E0, 2'd3);
    drain("after_reset");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
